aes_key_sched_ctrl: RTL and testbench
=====================================

// Module: aes_key_sched_ctrl
// PURPOSE
//  Sequencer and server for the AES-128 key schedule. Loads a 128-bit cipher key,
//  then runs the expansion FSM to produce w0..w43, one word per clock, into internal
//  44x32 storage. Serves 128-bit round keys to the cipher round core on request.
//  Early rounds are served while expansion is still in progress.
// PARAMETERS
//  SBOX_FILE  "sbox.mem"  $readmemh image of the 256-entry AES S-box
//  NUM_ROUNDS 10          AES-128 round count; fixed; round-key index range 0..NUM_ROUNDS
// PORTS
//  clk         in   1    clock; all logic on posedge
//  rst         in   1    synchronous reset, active-high
//  key_in      in   128  [0:127]; byte k = key_in[8k +: 8]; byte 0 is the MSB byte (FIPS-197 order)
//  key_load    in   1    start expansion of key_in; accepted only when key_ready=1
//  key_ready   out  1    controller can accept a new key
//  sched_valid out  1    all 44 words of the current schedule are written
//  word_cnt    out  6    number of schedule words written (0..44)
//  rk_req      in   1    round-key read request, sampled each clock
//  rk_idx      in   4    round-key index for rk_req
//  rk_valid    out  1    one-cycle response strobe
//  rk_data     out  128  {w[4k],w[4k+1],w[4k+2],w[4k+3]}, same byte order as key_in
//  rk_err      out  1    qualifies rk_valid: request was refused, rk_data=0
// BEHAVIOUR
//  Reset:
//   - State goes to IDLE. key_ready=1, sched_valid=0, word_cnt=0, rk_valid=0, rk_err=0, rk_data=0.
//   - rcon register=8'h01. Storage contents are don't-care.
//  FSM states: IDLE, EXPAND, DONE.
//  Key accept edge (key_load=1 and key_ready=1, in IDLE or DONE):
//   - w0..w3 <= key_in; word_cnt <= 4; rcon <= 8'h01.
//   - sched_valid <= 0; key_ready <= 0; state <= EXPAND.
//  key_load while key_ready=0 is ignored; no latching and no error.
//  EXPAND, per cycle, with i = word_cnt:
//   - i%4==0: w[i] = w[i-4] ^ SubWord(RotWord(w[i-1])) ^ {rcon,24'h0}.
//     After this step rcon <= xtime(rcon), i.e. (rcon<<1) ^ (rcon[7] ? 8'h1B : 0).
//   - otherwise: w[i] = w[i-4] ^ w[i-1].
//   - Then word_cnt <= i+1.
//   - The edge that writes w43 also sets word_cnt=44, sched_valid=1, key_ready=1, state DONE.
//   - Latency: sched_valid goes high exactly 40 clocks after the key-accept edge.
//  DONE: the schedule is held until the next key accept or rst.
//  Round-key read (registered, latency 1):
//   - rk_req=1 at edge N gives rk_valid=1 for the cycle after edge N.
//   - Reads are fully pipelined: one request per clock, no stall.
//   - Served (rk_err=0) when rk_idx<=NUM_ROUNDS and 4*rk_idx+3 < word_cnt (value before edge N).
//     This holds in EXPAND as well as in DONE.
//   - Refused (rk_err=1, rk_data=0) otherwise. This covers IDLE, idx>10, words not yet written,
//     and rk_req on the same edge as a key accept.
//   - No request: rk_valid=0; rk_err=0; rk_data holds its last value.
//  rst mid-EXPAND: the partial schedule is discarded and reset values apply on the next cycle.
//  A refused read never changes FSM state.
// TESTING
//  1 Reset: assert rst 2 clocks -> key_ready=1, sched_valid=0, word_cnt=0, rk_valid=0, rk_data=0.
//  2 Load 2b7e151628aed2a6abf7158809cf4f3c -> sched_valid rises 40 clocks after the accept edge;
//    idx0 -> key; idx1 -> a0fafe1788542cb123a339392a6c7605; idx10 -> d014f9a8c9ee2589e13f0cc8b6630ca6.
//  3 Early reads during EXPAND (fresh load, rk_idx=1):
//    issued at word_cnt=5 -> rk_err=1; issued at word_cnt=8 -> a0fafe17... served.
//    After DONE, idx=11 -> rk_valid=1, rk_err=1, rk_data=0.
//  4 key_load pulsed mid-EXPAND -> ignored, schedule still FIPS.
//    In DONE, load 128'h0 -> idx10 = b4ef5bcb3e92e21123e951cf6f8f188e.
//    rk_req on the accept edge -> rk_err=1.
//  5 rst at word_cnt=20 -> next cycle key_ready=1, sched_valid=0.
//    Reloading the FIPS key then reproduces test 2 exactly.
//  6 Back-to-back rk_req idx 0..10 on 11 consecutive clocks in DONE ->
//    11 consecutive rk_valid cycles, all rk_err=0, keys in order.

Source files
------------

// File: rtl/aes_key_sched_ctrl.sv
// aes_key_sched_ctrl
//   AES-128 key schedule sequencer and round-key server. A cipher key is loaded,
//   then w4..w43 are generated one word per clock into internal storage. Round
//   keys are served with one clock of latency. A read is answered as soon as its
//   four words exist, so early rounds can be fetched while expansion continues.
//
// Ports
//   clk          clock, all logic on posedge
//   rst          synchronous reset, active-high
//   key_in       128-bit cipher key, byte 0 in bits [127:120] (FIPS-197 order)
//   key_load     start expansion of key_in; accepted only when key_ready=1
//   key_ready    controller can accept a new key (IDLE or DONE)
//   sched_valid  all 44 words of the current schedule are written
//   word_cnt     number of schedule words written (0..44)
//   rk_req       round-key read request, sampled each clock
//   rk_idx       round-key index for rk_req
//   rk_valid     one-cycle response strobe
//   rk_data      {w[4k],w[4k+1],w[4k+2],w[4k+3]}, same byte order as key_in
//   rk_err       qualifies rk_valid: request refused, rk_data=0
module aes_key_sched_ctrl #(
  parameter int unsigned NUM_ROUNDS = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [127:0] key_in,
  input  logic         key_load,
  output logic         key_ready,
  output logic         sched_valid,
  output logic [5:0]   word_cnt,
  input  logic         rk_req,
  input  logic [3:0]   rk_idx,
  output logic         rk_valid,
  output logic [127:0] rk_data,
  output logic         rk_err
);

  localparam int unsigned NUM_WORDS = 4 * (NUM_ROUNDS + 1);

  // AES S-box, entry 0 in the most significant byte.
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXPAND,
    ST_DONE
  } state_t;

  // ~b * 8 addresses entry b counted from the MSB end of the table.
  function automatic logic [7:0] sbox_lookup(input logic [7:0] b);
    return SBOX[{~b, 3'b000} +: 8];
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] x);
    return {sbox_lookup(x[31:24]), sbox_lookup(x[23:16]),
            sbox_lookup(x[15:8]),  sbox_lookup(x[7:0])};
  endfunction

  state_t              r_state;
  state_t              w_state_nxt;
  logic [5:0]          r_word_cnt;
  logic [7:0]          r_rcon;
  logic [7:0]          w_rcon_nxt;
  // Sliding window of the last four words: [3] = w[i-4], [0] = w[i-1].
  logic [3:0][31:0]    r_win;
  logic [3:0][31:0]    r_sched [0:NUM_ROUNDS];
  logic                r_rk_valid;
  logic                r_rk_err;
  logic [127:0]        r_rk_data;

  logic                w_key_ready;
  logic                w_accept;
  logic                w_expand;
  logic                w_last;
  logic                w_rcon_step;
  logic [31:0]         w_rot_sub;
  logic [31:0]         w_new;
  logic                w_rk_ok;
  logic [3:0]          w_rd_idx;

  always_comb begin
    w_state_nxt = r_state;
    w_key_ready = 1'b0;
    w_expand    = 1'b0;
    w_last      = (r_word_cnt == 6'(NUM_WORDS - 1));
    unique case (r_state)
      ST_IDLE, ST_DONE: begin
        w_key_ready = 1'b1;
        if (key_load) w_state_nxt = ST_EXPAND;
      end
      ST_EXPAND: begin
        w_expand = 1'b1;
        if (w_last) w_state_nxt = ST_DONE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
    w_accept = key_load & w_key_ready;
  end

  always_comb begin
    w_rcon_step = (r_word_cnt[1:0] == 2'b00);
    w_rcon_nxt  = {r_rcon[6:0], 1'b0} ^ (r_rcon[7] ? 8'h1b : 8'h00);
    w_rot_sub   = sub_word({r_win[0][23:0], r_win[0][31:24]}) ^ {r_rcon, 24'h0};
    w_new       = r_win[3] ^ (w_rcon_step ? w_rot_sub : r_win[0]);
  end

  // A request colliding with a key accept is refused: slot 0 is being rewritten.
  always_comb begin
    w_rk_ok  = ~w_accept
             & (rk_idx <= 4'(NUM_ROUNDS))
             & ({rk_idx, 2'b11} < r_word_cnt);
    w_rd_idx = w_rk_ok ? rk_idx : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_word_cnt <= '0;
      r_rcon     <= 8'h01;
      r_rk_valid <= 1'b0;
      r_rk_err   <= 1'b0;
      r_rk_data  <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_word_cnt <= 6'd4;
        r_rcon     <= 8'h01;
      end else if (w_expand) begin
        r_word_cnt <= r_word_cnt + 6'd1;
        if (w_rcon_step) r_rcon <= w_rcon_nxt;
      end
      r_rk_valid <= rk_req;
      r_rk_err   <= rk_req & ~w_rk_ok;
      if (rk_req) r_rk_data <= w_rk_ok ? r_sched[w_rd_idx] : '0;
    end
  end

  // Schedule storage, organised as round keys; contents need no reset.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_sched[0] <= key_in;
      r_win      <= key_in;
    end else if (w_expand) begin
      r_sched[r_word_cnt[5:2]][~r_word_cnt[1:0]] <= w_new;
      r_win <= {r_win[2:0], w_new};
    end
  end

  assign key_ready   = w_key_ready;
  assign sched_valid = (r_state == ST_DONE);
  assign word_cnt    = r_word_cnt;
  assign rk_valid    = r_rk_valid;
  assign rk_err      = r_rk_err;
  assign rk_data     = r_rk_data;

endmodule

// File: tb/tb_aes_key_sched_ctrl.sv
module tb_aes_key_sched_ctrl;

  logic         clk      = 1'b0;
  logic         rst      = 1'b1;
  logic [127:0] key_in   = '0;
  logic         key_load = 1'b0;
  logic         key_ready;
  logic         sched_valid;
  logic [5:0]   word_cnt;
  logic         rk_req   = 1'b0;
  logic [3:0]   rk_idx   = '0;
  logic         rk_valid;
  logic [127:0] rk_data;
  logic         rk_err;

  int n_chk  = 0;
  int n_pass = 0;

  localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] ZERO_RK10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;
  logic [127:0] fips_rk [0:10];

  always #5 clk = ~clk;

  aes_key_sched_ctrl #(
    .NUM_ROUNDS(10)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .key_in     (key_in),
    .key_load   (key_load),
    .key_ready  (key_ready),
    .sched_valid(sched_valid),
    .word_cnt   (word_cnt),
    .rk_req     (rk_req),
    .rk_idx     (rk_idx),
    .rk_valid   (rk_valid),
    .rk_data    (rk_data),
    .rk_err     (rk_err)
  );

  task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [127:0] k);
    key_in   = k;
    key_load = 1'b1;
    step();
    key_load = 1'b0;
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    while (!sched_valid && cyc < 200) begin
      step();
      cyc++;
    end
  endtask

  task automatic rd(input logic [3:0] idx, output logic v, output logic e,
                    output logic [127:0] d);
    rk_req = 1'b1;
    rk_idx = idx;
    step();
    rk_req = 1'b0;
    v = rk_valid;
    e = rk_err;
    d = rk_data;
  endtask

  initial begin
    logic         v;
    logic         e;
    logic [127:0] d;
    int           cyc;

    fips_rk[0]  = FIPS_KEY;
    fips_rk[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
    fips_rk[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
    fips_rk[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
    fips_rk[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
    fips_rk[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
    fips_rk[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
    fips_rk[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
    fips_rk[8]  = 128'head27321b58dbad2312bf5607f8d292f;
    fips_rk[9]  = 128'hac7766f319fadc2128d12941575c006e;
    fips_rk[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

    // 1: reset
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_key_ready",   128'(key_ready),   128'(1));
    chk("rst_sched_valid", 128'(sched_valid), 128'(0));
    chk("rst_word_cnt",    128'(word_cnt),    128'(0));
    chk("rst_rk_valid",    128'(rk_valid),    128'(0));
    chk("rst_rk_err",      128'(rk_err),      128'(0));
    chk("rst_rk_data",     rk_data,           128'(0));

    // 2: FIPS key, latency and round keys
    load(FIPS_KEY);
    chk("acc_word_cnt",  128'(word_cnt),  128'(4));
    chk("acc_key_ready", 128'(key_ready), 128'(0));
    wait_done(cyc);
    chk("t2_latency",      128'(cyc),       128'(40));
    chk("t2_word_cnt",     128'(word_cnt),  128'(44));
    chk("t2_key_ready",    128'(key_ready), 128'(1));
    rd(4'd0, v, e, d);
    chk("t2_rk0_v", 128'(v), 128'(1));
    chk("t2_rk0_e", 128'(e), 128'(0));
    chk("t2_rk0",   d, fips_rk[0]);
    rd(4'd1, v, e, d);
    chk("t2_rk1",   d, fips_rk[1]);
    rd(4'd10, v, e, d);
    chk("t2_rk10_e", 128'(e), 128'(0));
    chk("t2_rk10",   d, fips_rk[10]);

    // 3: early reads during expansion
    load(FIPS_KEY);
    step();
    chk("t3_cnt5", 128'(word_cnt), 128'(5));
    rd(4'd1, v, e, d);
    chk("t3_early_v", 128'(v), 128'(1));
    chk("t3_early_e", 128'(e), 128'(1));
    chk("t3_early_d", d, 128'(0));
    step();
    step();
    chk("t3_cnt8", 128'(word_cnt), 128'(8));
    rd(4'd1, v, e, d);
    chk("t3_rk1_e", 128'(e), 128'(0));
    chk("t3_rk1",   d, fips_rk[1]);
    wait_done(cyc);
    chk("t3_done", 128'(sched_valid), 128'(1));
    rd(4'd11, v, e, d);
    chk("t3_idx11_v", 128'(v), 128'(1));
    chk("t3_idx11_e", 128'(e), 128'(1));
    chk("t3_idx11_d", d, 128'(0));

    // 4: key_load ignored mid-expansion; zero key; read on accept edge
    load(FIPS_KEY);
    step();
    step();
    step();
    key_in   = '0;
    key_load = 1'b1;
    step();
    key_load = 1'b0;
    chk("t4_ign_cnt",   128'(word_cnt),  128'(8));
    chk("t4_ign_ready", 128'(key_ready), 128'(0));
    wait_done(cyc);
    chk("t4_remaining", 128'(cyc), 128'(36));
    rd(4'd5, v, e, d);
    chk("t4_rk5", d, fips_rk[5]);
    rd(4'd10, v, e, d);
    chk("t4_rk10", d, fips_rk[10]);
    key_in   = '0;
    key_load = 1'b1;
    rk_req   = 1'b1;
    rk_idx   = 4'd0;
    step();
    key_load = 1'b0;
    rk_req   = 1'b0;
    chk("t4_acc_rd_v",  128'(rk_valid), 128'(1));
    chk("t4_acc_rd_e",  128'(rk_err),   128'(1));
    chk("t4_acc_rd_d",  rk_data,        128'(0));
    chk("t4_acc_cnt",   128'(word_cnt), 128'(4));
    wait_done(cyc);
    chk("t4_zero_lat", 128'(cyc), 128'(40));
    rd(4'd10, v, e, d);
    chk("t4_zero_rk10", d, ZERO_RK10);

    // 5: reset mid-expansion, then reload
    load(FIPS_KEY);
    cyc = 0;
    while (word_cnt != 6'd20 && cyc < 100) begin
      step();
      cyc++;
    end
    chk("t5_cnt20", 128'(word_cnt), 128'(20));
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("t5_key_ready",   128'(key_ready),   128'(1));
    chk("t5_sched_valid", 128'(sched_valid), 128'(0));
    chk("t5_word_cnt",    128'(word_cnt),    128'(0));
    rd(4'd0, v, e, d);
    chk("t5_idle_rd_e", 128'(e), 128'(1));
    load(FIPS_KEY);
    wait_done(cyc);
    chk("t5_latency", 128'(cyc), 128'(40));
    rd(4'd0, v, e, d);
    chk("t5_rk0", d, fips_rk[0]);
    rd(4'd1, v, e, d);
    chk("t5_rk1", d, fips_rk[1]);
    rd(4'd10, v, e, d);
    chk("t5_rk10", d, fips_rk[10]);

    // 6: back-to-back reads idx 0..10
    rk_req = 1'b1;
    rk_idx = 4'd0;
    for (int i = 0; i <= 10; i++) begin
      step();
      if (i < 10) rk_idx = 4'(i + 1);
      else rk_req = 1'b0;
      chk($sformatf("t6_v%0d", i), 128'(rk_valid), 128'(1));
      chk($sformatf("t6_e%0d", i), 128'(rk_err),   128'(0));
      chk($sformatf("t6_d%0d", i), rk_data,        fips_rk[i]);
    end
    step();
    chk("t6_idle_v",    128'(rk_valid), 128'(0));
    chk("t6_idle_e",    128'(rk_err),   128'(0));
    chk("t6_hold_data", rk_data,        fips_rk[10]);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
